// File: rtl/display_sequencer.sv
// display_sequencer: VGA pixel timing plus a scheduler that grants board-memory
// updates only during vertical blanking, revoking the grant when blanking ends.
module display_sequencer #(
    parameter int DIV       = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_PULSE   = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_PULSE   = 2,
    parameter int V_TOTAL   = 525,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    input  logic       upd_req,
    output logic       upd_grant,
    input  logic       upd_done,
    output logic       upd_abort
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_BLANK, GRANT} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [9:0]    h_n, v_n;
    logic          h_wrap, v_wrap, hs_n, vs_n, blank, blank_end, abort_n;

    always_comb begin
        div_n     = (div == DW'(DIV - 1)) ? '0 : div + 1'b1;
        h_wrap    = hcount == 10'(H_TOTAL - 1);
        v_wrap    = vcount == 10'(V_TOTAL - 1);
        h_n       = h_wrap ? '0 : hcount + 1'b1;
        v_n       = h_wrap ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
        hs_n      = (h_n >= 10'(H_VISIBLE + H_FRONT) && h_n < 10'(H_VISIBLE + H_FRONT + H_PULSE)) ? H_POL : ~H_POL;
        vs_n      = (v_n >= 10'(V_VISIBLE + V_FRONT) && v_n < 10'(V_VISIBLE + V_FRONT + V_PULSE)) ? V_POL : ~V_POL;
        blank     = vcount >= 10'(V_VISIBLE);
        blank_end = pix_tick && h_wrap && v_wrap;
        // A grant is never issued on the very edge that ends blanking.
        state_n   = (state == GRANT) ? ((upd_done || blank_end) ? IDLE : GRANT)
                  : (!upd_req ? IDLE : (blank && !blank_end) ? GRANT : WAIT_BLANK);
        abort_n   = state == GRANT && blank_end && !upd_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            pix_tick    <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            frame_start <= 1'b0;
            upd_abort   <= 1'b0;
            state       <= IDLE;
        end else begin
            div         <= div_n;
            pix_tick    <= div_n == DW'(DIV - 1);
            frame_start <= blank_end;
            upd_abort   <= abort_n;
            state       <= state_n;
            if (pix_tick) begin
                hcount <= h_n;
                vcount <= v_n;
                hsync  <= hs_n;
                vsync  <= vs_n;
            end
        end
    end

    assign video_on  = hcount < 10'(H_VISIBLE) && vcount < 10'(V_VISIBLE);
    assign upd_grant = state == GRANT;
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: reduced-size timing with DIV=2 and DIV=1 instances, checked
// every clock against an arithmetic model of position plus a grant/abort model.
module tb_display_sequencer;
    localparam int HV = 12, HF = 2, HP = 3, HT = 20;
    localparam int VV = 8, VF = 1, VP = 2, VT = 12;

    logic       clk = 1'b0, rst = 1'b1, upd_req = 1'b0, upd_done = 1'b0;
    logic [9:0] hc0, vc0, hc1, vc1;
    logic       pt0, hs0, vs0, vo0, fs0, gr0, ab0;
    logic       pt1, hs1, vs1, vo1, fs1, gr1, ab1;

    display_sequencer #(.DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_PULSE(HP), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_PULSE(VP), .V_TOTAL(VT), .H_POL(1'b0), .V_POL(1'b0)) u0 (
        .clk(clk), .rst(rst), .hcount(hc0), .vcount(vc0), .pix_tick(pt0), .hsync(hs0), .vsync(vs0),
        .video_on(vo0), .frame_start(fs0), .upd_req(upd_req), .upd_grant(gr0), .upd_done(upd_done),
        .upd_abort(ab0));

    display_sequencer #(.DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_PULSE(HP), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_PULSE(VP), .V_TOTAL(VT), .H_POL(1'b1), .V_POL(1'b1)) u1 (
        .clk(clk), .rst(rst), .hcount(hc1), .vcount(vc1), .pix_tick(pt1), .hsync(hs1), .vsync(vs1),
        .video_on(vo1), .frame_start(fs1), .upd_req(1'b0), .upd_grant(gr1), .upd_done(1'b0),
        .upd_abort(ab1));

    always #5 clk = ~clk;

    typedef struct {
        int   v;
        int   h;
        logic r;
        logic d;
        logic g;
        logic a;
    } vec_t;

    int vectors = 0, miscompares = 0;
    int n0 = 0, n1 = 0;
    int g = 0, ab = 0, fs_e0 = 0, fs_e1 = 0;

    // Pixel advances completed after n clock edges out of reset.
    function automatic int adv(input int n, input int dv);
        int a;
        a = n / dv - (dv == 1 ? 1 : 0);
        return a < 0 ? 0 : a;
    endfunction

    function automatic int tck(input int n, input int dv);
        return (n > 0 && n % dv == dv - 1) ? 1 : 0;
    endfunction

    function automatic int sync(input int p, input int s, input int len, input int pol);
        return (p >= s && p < s + len) ? pol : 1 - pol;
    endfunction

    function automatic int cur_h();
        return adv(n0, 2) % HT;
    endfunction

    function automatic int cur_v();
        return (adv(n0, 2) / HT) % VT;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n0 = 0; n1 = 0; g = 0; ab = 0; fs_e0 = 0; fs_e1 = 0;
    endtask

    task automatic model_edge();
        int ap, an, ap1, an1, blank, bend;
        ap = adv(n0, 2); n0++; an = adv(n0, 2);
        ap1 = adv(n1, 1); n1++; an1 = adv(n1, 1);
        blank = ((ap / HT) % VT) >= VV ? 1 : 0;
        bend = (an != ap && an % (HT * VT) == 0) ? 1 : 0;
        fs_e0 = bend;
        fs_e1 = (an1 != ap1 && an1 % (HT * VT) == 0) ? 1 : 0;
        ab = 0;
        if (g == 1) begin
            if (upd_done) g = 0;
            else if (bend == 1) begin g = 0; ab = 1; end
        end else if (upd_req && blank == 1 && bend == 0) g = 1;
    endtask

    task automatic check_all();
        int a0, a1, h, v, h1, v1;
        a0 = adv(n0, 2); h = a0 % HT; v = (a0 / HT) % VT;
        a1 = adv(n1, 1); h1 = a1 % HT; v1 = (a1 / HT) % VT;
        chk("hcount", 32'(hc0), h);
        chk("vcount", 32'(vc0), v);
        chk("pix_tick", 32'(pt0), tck(n0, 2));
        chk("hsync", 32'(hs0), sync(h, HV + HF, HP, 0));
        chk("vsync", 32'(vs0), sync(v, VV + VF, VP, 0));
        chk("video_on", 32'(vo0), (h < HV && v < VV) ? 1 : 0);
        chk("frame_start", 32'(fs0), fs_e0);
        chk("upd_grant", 32'(gr0), g);
        chk("upd_abort", 32'(ab0), ab);
        chk("d1_hcount", 32'(hc1), h1);
        chk("d1_vcount", 32'(vc1), v1);
        chk("d1_pix_tick", 32'(pt1), tck(n1, 1));
        chk("d1_hsync", 32'(hs1), sync(h1, HV + HF, HP, 1));
        chk("d1_vsync", 32'(vs1), sync(v1, VV + VF, VP, 1));
        chk("d1_video_on", 32'(vo1), (h1 < HV && v1 < VV) ? 1 : 0);
        chk("d1_frame_start", 32'(fs1), fs_e1);
        chk("d1_grant_abort", 32'({gr1, ab1}), 0);
    endtask

    task automatic step(input logic r, input logic d);
        upd_req = r;
        upd_done = d;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    initial begin
        // Each record: hold req=r until the last clk at (v,h), then apply (r,d) for that clk.
        vec_t tbl[14] = '{
            '{2, 0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{7, 19, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8, 0, 1'b1, 1'b0, 1'b1, 1'b0},
            '{9, 5, 1'b1, 1'b1, 1'b0, 1'b0},
            '{9, 6, 1'b1, 1'b0, 1'b1, 1'b0},
            '{11, 19, 1'b1, 1'b0, 1'b0, 1'b1},
            '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8, 0, 1'b1, 1'b0, 1'b1, 1'b0},
            '{11, 19, 1'b1, 1'b1, 1'b0, 1'b0},
            '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{10, 3, 1'b1, 1'b0, 1'b1, 1'b0},
            '{10, 4, 1'b0, 1'b0, 1'b1, 1'b0},
            '{11, 19, 1'b0, 1'b0, 1'b0, 1'b1},
            '{3, 0, 1'b0, 1'b0, 1'b0, 1'b0}
        };
        int guard;
        logic r;
        model_reset();
        #12 check_all();
        rst = 1'b0;
        for (int i = 0; i < $size(tbl); i++) begin
            guard = 0;
            while (!(cur_h() == tbl[i].h && cur_v() == tbl[i].v && tck(n0, 2) == 1) && guard < 2000) begin
                step(tbl[i].r, 1'b0);
                guard++;
            end
            if (guard >= 2000) begin
                vectors++; miscompares++;
                $display("FAIL tbl%0d_reach: position (%0d,%0d) not reached", i, tbl[i].v, tbl[i].h);
            end
            step(tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_grant", i), 32'(gr0), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_abort", i), 32'(ab0), 32'(tbl[i].a));
        end
        // Asynchronous reset while granted, away from any clock edge.
        guard = 0;
        while (!(g == 1 && cur_h() == 10) && guard < 2000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("pre_reset_grant", 32'(gr0), 1);
        #3 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        rst = 1'b0;
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) r = ~r;
            step(r, $urandom_range(0, 15) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
